// File: rtl/decode_stage_hz.sv
// RV32I decode stage with ID/EX pipeline register, load-use stall, EX flush and stall counter.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle WB write into the register reads.
module decode_stage_hz #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int STALL_W = 16,
  localparam int RW     = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validD,
  input  logic [31:0]        instrD,
  input  logic [XLEN-1:0]    pcD,
  input  logic [XLEN-1:0]    pcplus4D,
  input  logic               flushE,
  input  logic               regwriteW,
  input  logic [RW-1:0]      RdW,
  input  logic [XLEN-1:0]    resultW,
  output logic               stallD,
  output logic               validE,
  output logic               regwriteE,
  output logic               memwriteE,
  output logic               jumpE,
  output logic               branchE,
  output logic               alusrcE,
  output logic [1:0]         resultsrcE,
  output logic [2:0]         alucontrolE,
  output logic [XLEN-1:0]    Rd1E,
  output logic [XLEN-1:0]    Rd2E,
  output logic [XLEN-1:0]    ImmextE,
  output logic [XLEN-1:0]    pcE,
  output logic [XLEN-1:0]    pcplus4E,
  output logic [RW-1:0]      RdE,
  output logic [RW-1:0]      Rs1E,
  output logic [RW-1:0]      Rs2E,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [6:0]    opcodeD;
  logic [2:0]    funct3D;
  logic [RW-1:0] rs1D, rs2D, rdD;

  assign opcodeD = instrD[6:0];
  assign funct3D = instrD[14:12];
  assign rdD     = instrD[7 +: RW];
  assign rs1D    = instrD[15 +: RW];
  assign rs2D    = instrD[20 +: RW];

  logic            regwriteD, memwriteD, jumpD, branchD, alusrcD, useRs2D;
  logic [1:0]      resultsrcD;
  logic [2:0]      alucontrolD, aluOpD;
  logic [XLEN-1:0] immD;

  // funct7[5] only turns add into sub for register-register ops; addi ignores it.
  always_comb begin
    aluOpD = 3'b000;
    case (funct3D)
      3'b000:  aluOpD = (opcodeD == OP_R && instrD[30]) ? 3'b001 : 3'b000;
      3'b010:  aluOpD = 3'b101;
      3'b110:  aluOpD = 3'b011;
      3'b111:  aluOpD = 3'b010;
      default: aluOpD = 3'b000;
    endcase
  end

  always_comb begin
    regwriteD   = 1'b0;
    memwriteD   = 1'b0;
    jumpD       = 1'b0;
    branchD     = 1'b0;
    alusrcD     = 1'b0;
    useRs2D     = 1'b0;
    resultsrcD  = 2'b00;
    alucontrolD = 3'b000;
    immD        = '0;
    case (opcodeD)
      OP_LW: begin
        regwriteD  = 1'b1;
        alusrcD    = 1'b1;
        resultsrcD = 2'b01;
        immD       = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
      end
      OP_SW: begin
        memwriteD = 1'b1;
        alusrcD   = 1'b1;
        useRs2D   = 1'b1;
        immD      = {{(XLEN-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
      end
      OP_R: begin
        regwriteD   = 1'b1;
        useRs2D     = 1'b1;
        alucontrolD = aluOpD;
      end
      OP_I: begin
        regwriteD   = 1'b1;
        alusrcD     = 1'b1;
        alucontrolD = aluOpD;
        immD        = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
      end
      OP_BEQ: begin
        branchD     = 1'b1;
        useRs2D     = 1'b1;
        alucontrolD = 3'b001;
        immD        = {{(XLEN-13){instrD[31]}}, instrD[31], instrD[7],
                       instrD[30:25], instrD[11:8], 1'b0};
      end
      OP_JAL: begin
        jumpD      = 1'b1;
        regwriteD  = 1'b1;
        resultsrcD = 2'b10;
        immD       = {{(XLEN-21){instrD[31]}}, instrD[31], instrD[19:12],
                      instrD[20], instrD[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (regwriteW && RdW != '0) begin
      regs_q[RdW] <= resultW;
    end
  end

  logic [XLEN-1:0] rd1D, rd2D;

  always_comb begin
    rd1D = (rs1D == '0) ? '0 : regs_q[rs1D];
    rd2D = (rs2D == '0) ? '0 : regs_q[rs2D];
`ifdef DECODE_WB_BYPASS_EN
    if (regwriteW && RdW != '0 && RdW == rs1D) rd1D = resultW;
    if (regwriteW && RdW != '0 && RdW == rs2D) rd2D = resultW;
`endif
  end

  logic            validE_q, regwriteE_q, memwriteE_q, jumpE_q, branchE_q, alusrcE_q;
  logic [1:0]      resultsrcE_q;
  logic [2:0]      alucontrolE_q;
  logic [XLEN-1:0] rd1E_q, rd2E_q, immE_q, pcE_q, pcplus4E_q;
  logic [RW-1:0]   rdE_q, rs1E_q, rs2E_q;
  logic [STALL_W-1:0] stallCnt_q;

  // Load in EX whose destination feeds the ID instruction: hold ID one cycle.
  assign stallD = validD && validE_q && resultsrcE_q == 2'b01 && rdE_q != '0 &&
                  (rdE_q == rs1D || (useRs2D && rdE_q == rs2D));

  logic bubble, ctlEn;
  assign bubble = flushE || stallD;
  assign ctlEn  = validD && !bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validE_q      <= 1'b0;
      regwriteE_q   <= 1'b0;
      memwriteE_q   <= 1'b0;
      jumpE_q       <= 1'b0;
      branchE_q     <= 1'b0;
      alusrcE_q     <= 1'b0;
      resultsrcE_q  <= 2'b00;
      alucontrolE_q <= 3'b000;
      rd1E_q        <= '0;
      rd2E_q        <= '0;
      immE_q        <= '0;
      pcE_q         <= '0;
      pcplus4E_q    <= '0;
      rdE_q         <= '0;
      rs1E_q        <= '0;
      rs2E_q        <= '0;
    end else begin
      validE_q      <= ctlEn;
      regwriteE_q   <= ctlEn && regwriteD;
      memwriteE_q   <= ctlEn && memwriteD;
      jumpE_q       <= ctlEn && jumpD;
      branchE_q     <= ctlEn && branchD;
      alusrcE_q     <= ctlEn && alusrcD;
      resultsrcE_q  <= ctlEn ? resultsrcD : 2'b00;
      alucontrolE_q <= ctlEn ? alucontrolD : 3'b000;
      rd1E_q        <= rd1D;
      rd2E_q        <= rd2D;
      immE_q        <= immD;
      pcE_q         <= pcD;
      pcplus4E_q    <= pcplus4D;
      rdE_q         <= rdD;
      rs1E_q        <= rs1D;
      rs2E_q        <= rs2D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (stallD && !(&stallCnt_q)) begin
      stallCnt_q <= stallCnt_q + STALL_W'(1);
    end
  end

  assign validE      = validE_q;
  assign regwriteE   = regwriteE_q;
  assign memwriteE   = memwriteE_q;
  assign jumpE       = jumpE_q;
  assign branchE     = branchE_q;
  assign alusrcE     = alusrcE_q;
  assign resultsrcE  = resultsrcE_q;
  assign alucontrolE = alucontrolE_q;
  assign Rd1E        = rd1E_q;
  assign Rd2E        = rd2E_q;
  assign ImmextE     = immE_q;
  assign pcE         = pcE_q;
  assign pcplus4E    = pcplus4E_q;
  assign RdE         = rdE_q;
  assign Rs1E        = rs1E_q;
  assign Rs2E        = rs2E_q;
  assign stall_cnt   = stallCnt_q;

endmodule
